// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking network datapath.
//   SR_DEPTH    : synapse rows addressed by a presynaptic spike index
//   NR_DEPTH    : neuron rows
//   IDX_W       : spike index width derived from SR_DEPTH
//   spike_idx_t : one presynaptic spike index
package snn_pkg;

  localparam int unsigned SR_DEPTH = 16384;
  localparam int unsigned NR_DEPTH = 1024;

  // Address width for a table of 'depth' rows, never below one bit
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_width(SR_DEPTH);

  typedef logic [IDX_W-1:0] spike_idx_t;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO for spike indices with registered full/empty flags.
//   clk, reset : clock, asynchronous active-high reset
//   push/wdata : write wdata at tail (ignored while full)
//   pop        : advance head (ignored while empty)
//   head       : current head entry, combinational from read pointer
//   full/empty : registered occupancy flags
//   level      : occupancy 0..DEPTH
module spike_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  head,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              do_push;
  logic              do_pop;
  logic [LVL_W-1:0]  level_nxt;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next occupancy; a simultaneous push and pop leaves it unchanged
  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/spike_input_arbiter.sv
// Round-robin arbiter sharing the controller's single spike input port
// among N_REQ spike sources, buffered through a spike FIFO.
//   clk, reset        : clock, asynchronous active-high reset
//   req_valid/index   : per-requester spike request, index i at [i*IDX_W +: IDX_W]
//   req_ready         : one-hot grant (combinational)
//   input_occurred    : FIFO non-empty, to controller
//   input_index       : FIFO head, to controller
//   input_ack         : controller consumed the head
//   fifo_level        : FIFO occupancy
//   spike_count       : spikes popped, saturating
//   ack_err           : sticky, ack seen while FIFO empty
module spike_input_arbiter
  import snn_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned SR_DEPTH   = snn_pkg::SR_DEPTH,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned IDX_W     = idx_width(SR_DEPTH),
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*IDX_W-1:0] req_index,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   input_occurred,
  output logic [IDX_W-1:0]       input_index,
  input  logic                   input_ack,
  output logic [LVL_W-1:0]       fifo_level,
  output logic [CNT_W-1:0]       spike_count,
  output logic                   ack_err
);

  localparam int unsigned RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [RR_W-1:0]  rr_ptr;
  logic [RR_W-1:0]  grant_ptr;
  logic [RR_W-1:0]  scan_ptr;
  logic [RR_W:0]    scan_sum;
  logic             found;
  logic             transfer;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] req_idx_arr [N_REQ];

  // Unpack the flat request index bus
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_idx_arr[g] = req_index[g*IDX_W +: IDX_W];
  end

  // Scan from rr_ptr upward modulo N_REQ; first valid requester wins.
  // Uses only the registered full flag so grants never depend on input_ack.
  always_comb begin
    req_ready = '0;
    grant_ptr = '0;
    found     = 1'b0;
    scan_sum  = '0;
    scan_ptr  = '0;
    if (!fifo_full) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_sum = {1'b0, rr_ptr} + (RR_W+1)'(k);
        if (scan_sum >= (RR_W+1)'(N_REQ)) scan_sum = scan_sum - (RR_W+1)'(N_REQ);
        scan_ptr = scan_sum[RR_W-1:0];
        if (!found && req_valid[scan_ptr]) begin
          found               = 1'b1;
          grant_ptr           = scan_ptr;
          req_ready[scan_ptr] = 1'b1;
        end
      end
    end
  end

  assign transfer = found;
  assign pop      = input_ack && !fifo_empty;

  spike_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (transfer),
    .wdata (req_idx_arr[grant_ptr]),
    .pop   (pop),
    .head  (input_index),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign input_occurred = !fifo_empty;

  // Round-robin pointer, delivered-spike counter and ack error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      spike_count <= '0;
      ack_err     <= 1'b0;
    end else begin
      if (transfer) begin
        rr_ptr <= (grant_ptr == RR_W'(N_REQ - 1)) ? '0 : grant_ptr + RR_W'(1);
      end
      if (pop && (spike_count != '1)) spike_count <= spike_count + CNT_W'(1);
      if (input_ack && fifo_empty) ack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_input_arbiter.sv
// Self-checking bench for spike_input_arbiter using a scoreboard queue.
module tb_spike_input_arbiter;
  import snn_pkg::*;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IW    = 14;
  localparam int unsigned FD    = 8;

  logic                clk;
  logic                reset;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*IW-1:0] req_index;
  logic [N_REQ-1:0]    req_ready;
  logic                input_occurred;
  logic [IW-1:0]       input_index;
  logic                input_ack;
  logic [3:0]          fifo_level;
  logic [15:0]         spike_count;
  logic                ack_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  spike_idx_t sb_q[$];

  spike_input_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_index      (req_index),
    .req_ready      (req_ready),
    .input_occurred (input_occurred),
    .input_index    (input_index),
    .input_ack      (input_ack),
    .fifo_level     (fifo_level),
    .spike_count    (spike_count),
    .ack_err        (ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idx(input int r, input int v);
    req_index[r*IW +: IW] = IW'(v);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_index = '0; input_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (input_occurred !== 1'b0 || fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL reset_hold: occurred=%0b level=%0d required 0/0", input_occurred, fifo_level);
    end
    reset = 1'b0;
    step();
    #1;
    n_checks++;
    if (input_occurred !== 1'b0) begin n_fail++; $display("FAIL idle_occurred: got %0b required 0", input_occurred); end
    n_checks++;
    if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL idle_level: got %0d required 0", fifo_level); end
    n_checks++;
    if (spike_count !== 16'd0) begin n_fail++; $display("FAIL idle_count: got %0d required 0", spike_count); end
    n_checks++;
    if (req_ready !== 4'b0) begin n_fail++; $display("FAIL idle_ready: got %b required 0000", req_ready); end
    n_checks++;
    if (ack_err !== 1'b0) begin n_fail++; $display("FAIL idle_ack_err: got %0b required 0", ack_err); end
  endtask

  task automatic test_round_robin();
    int exp_grant = 0;
    int pops = 0;
    spike_idx_t e;
    for (int r = 0; r < 4; r++) set_idx(r, (r + 1) * 10);
    req_valid = 4'hF;
    for (int cyc = 0; cyc < 20 && pops < 5; cyc++) begin
      #1;
      n_checks++;
      if (req_ready !== (4'(1) << exp_grant)) begin
        n_fail++; $display("FAIL rr_grant: got %b required %b", req_ready, 4'(1) << exp_grant);
      end
      sb_q.push_back(IW'((exp_grant + 1) * 10));
      exp_grant = (exp_grant + 1) % 4;
      input_ack = input_occurred;
      if (input_occurred === 1'b1) begin
        e = sb_q.pop_front();
        n_checks++;
        if (input_index !== e) begin n_fail++; $display("FAIL rr_pop: got %0d required %0d", input_index, e); end
        pops++; exp_count++;
      end
      step();
      input_ack = 1'b0;
    end
    n_checks++;
    if (pops < 5) begin n_fail++; $display("FAIL rr_timeout: pops %0d required 5", pops); end
    req_valid = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (input_occurred !== 1'b1) break;
      e = sb_q.pop_front();
      n_checks++;
      if (input_index !== e) begin n_fail++; $display("FAIL rr_drain: got %0d required %0d", input_index, e); end
      exp_count++;
      input_ack = 1'b1;
      step();
      input_ack = 1'b0;
    end
    n_checks++;
    if (sb_q.size() != 0 || fifo_level !== 4'd0 || spike_count !== 16'(exp_count)) begin
      n_fail++; $display("FAIL rr_end: left=%0d level=%0d count=%0d required 0/0/%0d",
                         sb_q.size(), fifo_level, spike_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    int cur = 100;
    int lvl = 0;
    spike_idx_t e;
    req_valid = 4'b0100;
    for (int cyc = 0; cyc < 12; cyc++) begin
      set_idx(2, cur);
      #1;
      n_checks++;
      if (req_ready !== ((lvl < FD) ? 4'b0100 : 4'b0000)) begin
        n_fail++; $display("FAIL bp_ready: got %b at level %0d", req_ready, lvl);
      end
      if (lvl < FD) begin sb_q.push_back(IW'(cur)); cur++; lvl++; end
      step();
    end
    #1;
    n_checks++;
    if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL bp_level_full: got %0d required 8", fifo_level); end
    n_checks++;
    if (input_index !== 14'd100) begin n_fail++; $display("FAIL bp_head: got %0d required 100", input_index); end
    // Ack while full must not open the grant in the same cycle
    input_ack = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_ack: got %b required 0000", req_ready); end
    e = sb_q.pop_front(); exp_count++;
    step();
    input_ack = 1'b0;
    #1;
    n_checks++;
    if (input_index !== 14'd101 || fifo_level !== 4'd7) begin
      n_fail++; $display("FAIL bp_advance: head=%0d level=%0d required 101/7", input_index, fifo_level);
    end
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_reopen: got %b required 0100", req_ready); end
    sb_q.push_back(IW'(108));
    step();
    set_idx(2, 109);
    #1;
    n_checks++;
    if (fifo_level !== 4'd8 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL bp_refill: level=%0d ready=%b required 8/0000", fifo_level, req_ready);
    end
    req_valid = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (input_occurred !== 1'b1) break;
      e = sb_q.pop_front();
      n_checks++;
      if (input_index !== e) begin n_fail++; $display("FAIL bp_drain: got %0d required %0d", input_index, e); end
      exp_count++;
      input_ack = 1'b1;
      step();
      input_ack = 1'b0;
    end
    n_checks++;
    if (sb_q.size() != 0 || fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL bp_end: left=%0d level=%0d required 0/0", sb_q.size(), fifo_level);
    end
  endtask

  task automatic test_push_pop();
    spike_idx_t e;
    req_valid = 4'b0001;
    for (int v = 50; v < 53; v++) begin
      set_idx(0, v);
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL pp_fill: got %b required 0001", req_ready); end
      sb_q.push_back(IW'(v));
      step();
    end
    for (int v = 53; v < 55; v++) begin
      set_idx(0, v);
      input_ack = 1'b1;
      #1;
      n_checks++;
      if (fifo_level !== 4'd3 || req_ready !== 4'b0001) begin
        n_fail++; $display("FAIL pp_pre: level=%0d ready=%b required 3/0001", fifo_level, req_ready);
      end
      e = sb_q.pop_front();
      n_checks++;
      if (input_index !== e) begin n_fail++; $display("FAIL pp_pop: got %0d required %0d", input_index, e); end
      exp_count++;
      sb_q.push_back(IW'(v));
      step();
      input_ack = 1'b0;
      #1;
      n_checks++;
      if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL pp_level: got %0d required 3", fifo_level); end
    end
    req_valid = '0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (input_occurred !== 1'b1) break;
      e = sb_q.pop_front();
      n_checks++;
      if (input_index !== e) begin n_fail++; $display("FAIL pp_drain: got %0d required %0d", input_index, e); end
      exp_count++;
      input_ack = 1'b1;
      step();
      input_ack = 1'b0;
    end
    n_checks++;
    if (sb_q.size() != 0 || spike_count !== 16'(exp_count)) begin
      n_fail++; $display("FAIL pp_end: left=%0d count=%0d required 0/%0d", sb_q.size(), spike_count, exp_count);
    end
  endtask

  task automatic test_ack_empty();
    #1;
    n_checks++;
    if (input_occurred !== 1'b0 || ack_err !== 1'b0) begin
      n_fail++; $display("FAIL ae_pre: occurred=%0b ack_err=%0b required 0/0", input_occurred, ack_err);
    end
    input_ack = 1'b1;
    step();
    input_ack = 1'b0;
    #1;
    n_checks++;
    if (ack_err !== 1'b1) begin n_fail++; $display("FAIL ae_set: got %0b required 1", ack_err); end
    n_checks++;
    if (spike_count !== 16'(exp_count) || fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL ae_state: count=%0d level=%0d required %0d/0", spike_count, fifo_level, exp_count);
    end
    repeat (3) step();
    n_checks++;
    if (ack_err !== 1'b1) begin n_fail++; $display("FAIL ae_sticky: got %0b required 1", ack_err); end
  endtask

  task automatic test_reset_mid();
    spike_idx_t e;
    req_valid = 4'b0010;
    for (int v = 60; v < 65; v++) begin
      set_idx(1, v);
      #1;
      sb_q.push_back(IW'(v));
      step();
    end
    req_valid = '0;
    #1;
    n_checks++;
    if (fifo_level !== 4'd5) begin n_fail++; $display("FAIL rm_level5: got %0d required 5", fifo_level); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (fifo_level !== 4'd0 || input_occurred !== 1'b0) begin
      n_fail++; $display("FAIL rm_clear: level=%0d occurred=%0b required 0/0", fifo_level, input_occurred);
    end
    n_checks++;
    if (spike_count !== 16'd0 || ack_err !== 1'b0) begin
      n_fail++; $display("FAIL rm_counters: count=%0d ack_err=%0b required 0/0", spike_count, ack_err);
    end
    sb_q.delete();
    exp_count = 0;
    step();
    reset = 1'b0;
    step();
    set_idx(1, 7);
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_grant: got %b required 0010", req_ready); end
    sb_q.push_back(IW'(7));
    step();
    req_valid = '0;
    #1;
    e = sb_q.pop_front();
    n_checks++;
    if (input_occurred !== 1'b1 || input_index !== e) begin
      n_fail++; $display("FAIL rm_present: occurred=%0b index=%0d required 1/%0d", input_occurred, input_index, e);
    end
    input_ack = 1'b1;
    exp_count++;
    step();
    input_ack = 1'b0;
    #1;
    n_checks++;
    if (spike_count !== 16'(exp_count) || input_occurred !== 1'b0 || ack_err !== 1'b0) begin
      n_fail++; $display("FAIL rm_after: count=%0d occurred=%0b ack_err=%0b required %0d/0/0",
                         spike_count, input_occurred, ack_err, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_ack_empty();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
